alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter: LEN, 8, data width; it SHALL match the ALU's LEN.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 in_valid  in  1  instruction offered.
REQ-005 in_ready  out  1  instruction accepted when in_valid&in_ready at a clk edge.
REQ-006 in_op  in  4  ALU opcode (0000 add … 1000 shr).
REQ-007 in_ld  in  1  1 = load immediate instead of ALU op.
REQ-008 in_rd, in_ra, in_rb  in  2 each  destination and source register indices.
REQ-009 in_imm  in  LEN  immediate for loads.
REQ-010 alu_a, alu_b  out  LEN  registered operands to ALU A/B.
REQ-011 alu_code  out  4  registered opcode to ALU code.
REQ-012 alu_out  in  LEN  combinational ALU result.
REQ-013 rd_sel  in  2; rd_data  out  LEN  combinational register read for observation.
REQ-014 done  out  1  one-cycle pulse on writeback.
REQ-015 zero  out  1  1 when the last written value was 0.
REQ-016 carry  out  1  carry/borrow/shifted-out bit; present only under CFG.

Function
REQ-017 It SHALL hold a 4 x LEN register file r0..r3; every register is writable.
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WB; in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on handshake, it SHALL latch rd, ra, rb, op, ld, imm; ld=1 -> WB, ld=0 -> READ; no handshake -> stay.
REQ-020 READ: alu_a<=r[ra], alu_b<=r[rb], alu_code<=op; -> EXEC.
REQ-021 EXEC: result<=alu_out (operands stable one full cycle); -> WB.
REQ-022 WB: r[rd]<=result (or imm if ld); zero<=(written==0); done=1 this cycle only; -> IDLE.
REQ-023 Latency: ALU op written 3 cycles after the accept edge; load 1 cycle after; next accept is possible in the cycle after WB.
REQ-024 Sources SHALL be sampled in READ, so ra/rb equal to rd SHALL use the pre-write value.
REQ-025 Writeback width SHALL be LEN; overflow bits are discarded (the ALU truncates).
REQ-026 Opcodes 1001-1111 SHALL be executed normally (ALU returns 0), writing 0 and setting zero=1.
REQ-027 alu_a, alu_b, alu_code SHALL hold their values outside READ; on a load, alu_* SHALL be unchanged.
REQ-028 in_* changes while not in IDLE SHALL have no effect.

Reset
REQ-029 On rst, it SHALL immediately set state=IDLE, r0..r3=0, alu_a=alu_b=0, alu_code=4'b1111, done=0, zero=0, carry=0.
REQ-030 rst asserted mid-operation SHALL abort it without writeback; in_ready=1 the first cycle after release.

Configuration
REQ-031 Macro ALU_EXEC_CARRY_EN: when defined, port carry SHALL exist and update in WB only for ALU ops.
REQ-032 carry values: add = bit LEN of alu_a+alu_b; sub = 1 if alu_a<alu_b; shl = alu_a[LEN-1]; shr = alu_a[0]; other ops = 0.
REQ-033 carry SHALL be unchanged on loads.
REQ-034 Undefined: no carry port or logic; all other behaviour identical.

Verification
REQ-035 Load r1=5, r2=3; add rd=0 ra=1 rb=2 -> done 3 cycles after accept, rd_data(r0)=8, zero=0.
REQ-036 r1=5, r2=5, op=0001 rd=3 -> r3=0, zero=1; with CFG carry=0.
REQ-037 r1=200, r2=100, add -> r0=44 (LEN=8); with CFG carry=1.
REQ-038 in_valid held high continuously -> in_ready low in READ/EXEC/WB, exactly one accept per 4 cycles, no dropped or duplicated instruction.
REQ-039 rd=ra=1 (r1=7) shl -> r1=14 and source read 7; op=1010 -> written 0, zero=1.
REQ-040 rst asserted during EXEC of a write to r2 -> r2=0, done never pulses, in_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequencer that feeds an external combinational ALU from a
// 4-entry register file and writes the result back.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : instruction handshake (ready only while idle)
//   in_op, in_ld        : ALU opcode / load-immediate select
//   in_rd, in_ra, in_rb : destination and source register indices
//   in_imm              : immediate for loads
//   alu_a/alu_b/alu_code: registered ALU operands and opcode
//   alu_out             : ALU result (combinational, from outside)
//   rd_sel/rd_data      : combinational register read for observation
//   done                : high for the single writeback cycle
//   zero                : last written value was zero
//   carry               : carry/borrow/shifted-out bit (only when the
//                         macro ALU_EXEC_CARRY_EN is defined)
module alu_exec_ctrl #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic           in_ld,
  input  logic [1:0]     in_rd,
  input  logic [1:0]     in_ra,
  input  logic [1:0]     in_rb,
  input  logic [LEN-1:0] in_imm,
  output logic [LEN-1:0] alu_a,
  output logic [LEN-1:0] alu_b,
  output logic [3:0]     alu_code,
  input  logic [LEN-1:0] alu_out,
  input  logic [1:0]     rd_sel,
  output logic [LEN-1:0] rd_data,
  output logic           done,
  output logic           zero
`ifdef ALU_EXEC_CARRY_EN
  ,
  output logic           carry
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t         state_q, state_d;
  logic [1:0]     rd_q, ra_q, rb_q;
  logic [3:0]     op_q;
  logic           ld_q;
  logic [LEN-1:0] imm_q;
  logic [LEN-1:0] result_q;
  logic [LEN-1:0] regs_q [4];
  logic [LEN-1:0] alu_a_q, alu_b_q;
  logic [3:0]     alu_code_q;
  logic           zero_q;
  logic [LEN-1:0] wb_data;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_ld ? WB : READ;
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_data = ld_q ? imm_q : result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      op_q       <= '0;
      ld_q       <= 1'b0;
      imm_q      <= '0;
      result_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_code_q <= '1;
      zero_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          rd_q  <= in_rd;
          ra_q  <= in_ra;
          rb_q  <= in_rb;
          op_q  <= in_op;
          ld_q  <= in_ld;
          imm_q <= in_imm;
        end
        READ: begin
          alu_a_q    <= regs_q[ra_q];
          alu_b_q    <= regs_q[rb_q];
          alu_code_q <= op_q;
        end
        EXEC: result_q <= alu_out;
        WB: begin
          regs_q[rd_q] <= wb_data;
          zero_q       <= (wb_data == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_EXEC_CARRY_EN
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;

  logic           carry_q, carry_d;
  logic [LEN:0]   sum;

  // Derived from the held operand registers, which are stable through WB.
  always_comb begin
    sum     = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    carry_d = 1'b0;
    case (alu_code_q)
      OP_ADD:  carry_d = sum[LEN];
      OP_SUB:  carry_d = (alu_a_q < alu_b_q);
      OP_SHL:  carry_d = alu_a_q[LEN-1];
      OP_SHR:  carry_d = alu_a_q[0];
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else if (state_q == WB && !ld_q) carry_q <= carry_d;
  end

  assign carry = carry_q;
`endif

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_code = alu_code_q;
  assign zero     = zero_q;
  assign rd_data  = regs_q[rd_sel];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;
  localparam int LEN = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic           in_ld;
  logic [1:0]     in_rd, in_ra, in_rb;
  logic [LEN-1:0] in_imm;
  logic [LEN-1:0] alu_a, alu_b;
  logic [3:0]     alu_code;
  logic [LEN-1:0] alu_out;
  logic [1:0]     rd_sel;
  logic [LEN-1:0] rd_data;
  logic           done;
  logic           zero;
`ifdef ALU_EXEC_CARRY_EN
  logic           carry;
`endif

  alu_exec_ctrl #(.LEN(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ld(in_ld), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_out(alu_out), .rd_sel(rd_sel), .rd_data(rd_data), .done(done),
    .zero(zero)
`ifdef ALU_EXEC_CARRY_EN
    , .carry(carry)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 add,1 sub,2 and,3 or,4 xor,5 not a,6 pass a,7 shl,8 shr, else 0.
  function automatic logic [LEN-1:0] alu_f(input logic [LEN-1:0] a, b, input logic [3:0] c);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a;
      4'd7: return a << 1;
      4'd8: return a >> 1;
      default: return '0;
    endcase
  endfunction

  function automatic logic carry_f(input logic [LEN-1:0] a, b, input logic [3:0] c);
    int s;
    s = int'(a) + int'(b);
    case (c)
      4'd0: return s > 255;
      4'd1: return a < b;
      4'd7: return a[LEN-1];
      4'd8: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_code);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted instruction computes its result at
  // once from the register values at accept time; its visible effects appear
  // after a fixed number of clock edges.
  logic [LEN-1:0] m_regs [4];
  int             m_left;
  logic [LEN-1:0] m_a, m_b, m_res, m_ta, m_tb;
  logic [3:0]     m_code, m_top;
  logic           m_zero, m_carry, m_cy, m_tld;
  logic [1:0]     m_trd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_left = 0; m_a = '0; m_b = '0; m_code = 4'hF;
      m_zero = 1'b0; m_carry = 1'b0;
    end else if (m_left == 0) begin
      if (in_valid) begin
        m_tld = in_ld; m_trd = in_rd; m_top = in_op;
        m_ta = m_regs[in_ra]; m_tb = m_regs[in_rb];
        m_res = in_ld ? in_imm : alu_f(m_ta, m_tb, in_op);
        m_cy  = carry_f(m_ta, m_tb, in_op);
        m_left = in_ld ? 1 : 3;
      end
    end else begin
      if (m_left == 3) begin m_a = m_ta; m_b = m_tb; m_code = m_top; end
      if (m_left == 1) begin
        m_regs[m_trd] = m_res;
        m_zero = (m_res == '0);
        if (!m_tld) m_carry = m_cy;
      end
      m_left--;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", in_ready, m_left == 0);
      chk("done", done, m_left == 1);
      chk("zero", zero, m_zero);
      chk("rd_data", rd_data, m_regs[rd_sel]);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_code", alu_code, m_code);
`ifdef ALU_EXEC_CARRY_EN
      chk("carry", carry, m_carry);
`endif
    end
  end

  int acc_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (done) done_cnt++;
  end

  // Offer one instruction from IDLE, scramble the inputs after accept, and
  // measure negedges from the accept edge to the done pulse.
  task automatic issue(input logic ld, input logic [3:0] op, input logic [1:0] rd, ra, rb,
                       input logic [LEN-1:0] imm, output int lat);
    in_valid = 1'b1; in_ld = ld; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_ld = 1'($urandom); in_op = 4'($urandom); in_rd = 2'($urandom);
    in_ra = 2'($urandom); in_rb = 2'($urandom); in_imm = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    @(posedge clk); #2;
  endtask

  task automatic readreg(input string name, input logic [1:0] idx, input logic [LEN-1:0] exp);
    rd_sel = idx; #1;
    chk(name, rd_data, exp);
  endtask

  int lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_ld = 1'b0;
    in_rd = '0; in_ra = '0; in_rb = '0; in_imm = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_code", alu_code, 4'hF);
    chk("rst_zero", zero, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // r1=5, r2=3, r0=r1+r2
    issue(1, 4'd0, 2'd1, 2'd0, 2'd0, 8'd5, lat); chk("lat_load", lat, 1);
    issue(1, 4'd0, 2'd2, 2'd0, 2'd0, 8'd3, lat);
    chk("load_keeps_alu_code", alu_code, 4'hF);
    issue(0, 4'd0, 2'd0, 2'd1, 2'd2, 8'd0, lat); chk("lat_alu", lat, 3);
    readreg("add_r0", 2'd0, 8'd8);
    chk("add_zero", zero, 0);

    // r1=5, r2=5, r3=r1-r2 -> 0
    issue(1, 4'd0, 2'd2, 2'd0, 2'd0, 8'd5, lat);
    issue(0, 4'd1, 2'd3, 2'd1, 2'd2, 8'd0, lat);
    readreg("sub_r3", 2'd3, 8'd0);
    chk("sub_zero", zero, 1);
`ifdef ALU_EXEC_CARRY_EN
    chk("sub_carry", carry, 0);
`endif

    // 200 + 100 wraps to 44
    issue(1, 4'd0, 2'd1, 2'd0, 2'd0, 8'd200, lat);
    issue(1, 4'd0, 2'd2, 2'd0, 2'd0, 8'd100, lat);
    issue(0, 4'd0, 2'd0, 2'd1, 2'd2, 8'd0, lat);
    readreg("wrap_r0", 2'd0, 8'd44);
`ifdef ALU_EXEC_CARRY_EN
    chk("wrap_carry", carry, 1);
    issue(1, 4'd0, 2'd3, 2'd0, 2'd0, 8'd1, lat);
    chk("load_keeps_carry", carry, 1);
`endif

    // r1=7, r1 = r1<<1 reads the pre-write value
    issue(1, 4'd0, 2'd1, 2'd0, 2'd0, 8'd7, lat);
    issue(0, 4'd7, 2'd1, 2'd1, 2'd1, 8'd0, lat);
    readreg("shl_r1", 2'd1, 8'd14);
    chk("shl_src", alu_a, 8'd7);
    issue(0, 4'd10, 2'd2, 2'd1, 2'd1, 8'd0, lat);
    readreg("op1010_r2", 2'd2, 8'd0);
    chk("op1010_zero", zero, 1);

    // Continuous valid: r0=0, r1=3, then r0+=r1 offered for 16 cycles
    issue(1, 4'd0, 2'd0, 2'd0, 2'd0, 8'd0, lat);
    issue(1, 4'd0, 2'd1, 2'd0, 2'd0, 8'd3, lat);
    acc_cnt = 0;
    in_valid = 1'b1; in_ld = 1'b0; in_op = 4'd0; in_rd = 2'd0; in_ra = 2'd0; in_rb = 2'd1;
    repeat (16) @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("stream_accepts", acc_cnt, 4);
    readreg("stream_r0", 2'd0, 8'd12);

    // Reset during EXEC of a write to r2
    issue(1, 4'd0, 2'd2, 2'd0, 2'd0, 8'd9, lat);
    in_valid = 1'b1; in_ld = 1'b0; in_op = 4'd0; in_rd = 2'd2; in_ra = 2'd1; in_rb = 2'd1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    done_cnt = 0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    repeat (4) @(posedge clk);
    #2;
    chk("rst_no_done", done_cnt, 0);
    readreg("rst_r2", 2'd2, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
